// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and signed
// restoring divide, one bit per cycle, results held in registered HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    // MULT: {acc_hi, acc_lo, q_m1} is the Booth accumulator, operand = sign-extended M.
    // DIV:  acc_hi = partial remainder R, acc_lo = Q, operand = |b|.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             q_m1;
    logic [WIDTH:0]   operand;
    logic             neg_q;
    logic             neg_r;

    // Booth step; the extra accumulator bit keeps P_hi - (-2^(W-1)) from overflowing.
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH+1:0] booth_shift;

    always_comb begin
        booth_sum = acc_hi;
        case ({acc_lo[0], q_m1})
            2'b01:   booth_sum = acc_hi + operand;
            2'b10:   booth_sum = acc_hi - operand;
            default: booth_sum = acc_hi;
        endcase
        booth_shift = {booth_sum[WIDTH], booth_sum, acc_lo};
    end

    // Restoring divide step.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] diff;
    logic             diff_neg;

    always_comb begin
        r_shift  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        diff     = {1'b0, r_shift} - {1'b0, operand};
        diff_neg = diff[WIDTH+1];
    end

    // |a| read as unsigned is exact even for -2^(W-1); |b| carries a spare bit.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        a_mag    = a_in[WIDTH-1] ? -a_in : a_in;
        b_mag    = {1'b0, (b_in[WIDTH-1] ? -b_in : b_in)};
        quot_fix = neg_q ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            q_m1     <= 1'b0;
            operand  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= '0;
                        if (op && (b_in == '0)) begin
                            // Divide by zero completes at once; HI/LO keep old values.
                            state    <= S_DONE;
                            div_zero <= 1'b1;
                        end else if (op) begin
                            state   <= S_DIV;
                            acc_hi  <= '0;
                            acc_lo  <= a_mag;
                            operand <= b_mag;
                            neg_q   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            neg_r   <= a_in[WIDTH-1];
                        end else begin
                            state   <= S_MULT;
                            acc_hi  <= '0;
                            acc_lo  <= b_in;
                            q_m1    <= 1'b0;
                            operand <= {a_in[WIDTH-1], a_in};
                        end
                    end
                end
                S_MULT: begin
                    acc_hi <= booth_shift[2*WIDTH+1:WIDTH+1];
                    acc_lo <= booth_shift[WIDTH:1];
                    q_m1   <= booth_shift[0];
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state    <= S_DONE;
                        hi_out   <= booth_shift[2*WIDTH:WIDTH+1];
                        lo_out   <= booth_shift[WIDTH:1];
                        div_zero <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc_hi <= diff_neg ? r_shift : diff[WIDTH:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], ~diff_neg};
                    count  <= count + 1'b1;
                    if (count == LAST)
                        state <= S_FIX;
                end
                S_FIX: begin
                    state    <= S_DONE;
                    hi_out   <= rem_fix;
                    lo_out   <= quot_fix;
                    div_zero <= 1'b0;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, div-by-zero, ignored
// starts and asynchronous reset abort.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // lat = edges after the acceptance edge until done is seen (0 = done right after it).
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D;
        lat = 0; bcyc = 0;
        while (!done && lat < 100) begin
            bcyc += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) begin
            checks++; errors++;
            $display("FAIL op_timeout got no done exp done within 100 cycles");
        end
        bcyc += int'(busy);
        hi = hi_out; lo = lo_out; dz = div_zero;
        @(posedge clk); #1;
        bcyc += int'(busy);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_zero, hi_out, lo_out} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state got b%0b d%0b z%0b hi %h lo %h exp all 0",
                     busy, done, div_zero, hi_out, lo_out);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_mult();
        int lat, bc; logic [31:0] hi, lo; logic dz;
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, bc, hi, lo, dz);
        checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency got %0d exp 32", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 33", bc); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_neg_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_neg_lo got %h exp ffffffeb", lo); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL mul_dz got %b exp 0", dz); end

        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bc, hi, lo, dz);
        checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL mul_min_hi got %h exp 40000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mul_min_lo got %h exp 00000000", lo); end
    endtask

    task automatic test_div();
        int lat, bc; logic [31:0] hi, lo; logic dz;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc, hi, lo, dz);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_q got %h exp fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_r got %h exp ffffffff", hi); end

        // 7 / -2 = -3 remainder +1
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bc, hi, lo, dz);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_q got %h exp fffffffd", lo); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL div_negb_r got %h exp 00000001", hi); end

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, hi, lo, dz);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_wrap_q got %h exp 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_wrap_r got %h exp 00000000", hi); end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic [31:0] hi, lo; logic dz;
        // 0x451 / 0x20 = 0x22 r 0x11 sets up HI/LO
        run_op(1'b1, 32'h451, 32'h20, lat, bc, hi, lo, dz);
        checks++; if ({hi, lo} !== {32'h11, 32'h22}) begin errors++; $display("FAIL dz_setup got %h %h exp 00000011 00000022", hi, lo); end

        run_op(1'b1, 32'd5, 32'd0, lat, bc, hi, lo, dz);
        checks++; if (lat !== 0) begin errors++; $display("FAIL dz_latency got %0d exp 0 extra edges", lat); end
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", dz); end
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL dz_hi_hold got %h exp 00000011", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL dz_lo_hold got %h exp 00000022", lo); end

        run_op(1'b1, 32'd100, 32'd7, lat, bc, hi, lo, dz);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL dz_next_q got %h exp 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL dz_next_r got %h exp 00000002", hi); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_clear got %b exp 0", dz); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd1000; b_in = 32'hFFFF_FFFB;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 1'b1; a_in = 32'd3; b_in = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL ign_latency got %0d exp 32", lat); end
        checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ign_hi got %h exp ffffffff", hi_out); end
        checks++; if (lo_out !== 32'hFFFF_EC78) begin errors++; $display("FAIL ign_lo got %h exp ffffec78", lo_out); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle got busy %b exp 0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat, bc; logic [31:0] hi, lo; logic dz;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd6; b_in = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b exp 1", busy); end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_zero, hi_out, lo_out} !== 67'd0) begin
            errors++;
            $display("FAIL abort_clear got b%0b d%0b z%0b hi %h lo %h exp all 0",
                     busy, done, div_zero, hi_out, lo_out);
        end
        @(negedge clk); reset = 1'b1;
        run_op(1'b0, 32'd3, 32'd4, lat, bc, hi, lo, dz);
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL post_reset_lo got %h exp 0000000c", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL post_reset_hi got %h exp 00000000", hi); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL post_reset_latency got %0d exp 32", lat); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
